// File: rtl/rot_pkg.sv
// Shared types and defaults for the frame capture / rotation path.
package rot_pkg;

    localparam int PIX_W     = 24;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_HANDOFF  = 2'd2,
        ST_WAIT_ROT = 2'd3
    } state_t;

endpackage

// File: rtl/frame_addr_gen.sv
// Column/row counters and the linear frame-buffer write address.
module frame_addr_gen
    import rot_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 19,
    parameter int COL_W  = $clog2(IMG_W + 1),
    parameter int ROW_W  = $clog2(IMG_H + 1)
) (
    input  logic              Clk_in,
    input  logic              Rst_n_in,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic              i_line_adv,
    output logic [COL_W-1:0]  o_col,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_line_full,
    output logic              o_last_line
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  w_col_inc;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_col_inc  = r_col + COL_W'(i_inc);
    // Saturate at the final pixel so the counter never leaves the frame.
    assign w_addr_inc = (i_inc && (r_addr != LAST_ADDR)) ?
                        r_addr + ADDR_W'(1) : r_addr;

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_clr) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_line_adv) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
            // Next line base is (row+1)*IMG_W, reached by skipping the rest.
            if (!o_last_line)
                r_addr <= w_addr_inc + (ADDR_W'(IMG_W) - ADDR_W'(w_col_inc));
            else
                r_addr <= w_addr_inc;
        end else if (i_inc) begin
            r_col  <= w_col_inc;
            r_addr <= w_addr_inc;
        end
    end

    assign o_col       = r_col;
    assign o_addr      = r_addr;
    assign o_line_full = (r_col == COL_W'(IMG_W));
    assign o_last_line = (r_row == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/frame_write_ctrl.sv
// Frame capture sequencer with rotation-engine handshake.
// Optional LINE_CHECK_EN adds a sticky line-length error flag.
module frame_write_ctrl
    import rot_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              Clk_in,
    input  logic              Rst_n_in,
    input  logic              pixel_ready,
    input  logic              pixel_valid,
    input  logic              line_end,
    input  logic [PIX_W-1:0]  pixel_data,
    input  logic              rot_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              rot_start,
    output logic              frame_done,
    output logic              busy,
    output logic              line_err
);

    localparam int COL_W = $clog2(IMG_W + 1);

    state_t            r_state;
    logic              r_ready_q;
    logic              r_seen_busy;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_rot_start;

    logic              w_rise;
    logic              w_start;
    logic              w_fill;
    logic              w_wr;
    logic              w_adv;
    logic [COL_W-1:0]  w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_line_full;
    logic              w_last_line;

    assign w_rise  = pixel_ready & ~r_ready_q;
    assign w_start = (r_state == ST_IDLE) & w_rise & ~rot_busy;
    assign w_fill  = (r_state == ST_FILL) & pixel_ready;
    assign w_wr    = w_fill & pixel_valid & ~w_line_full;
    assign w_adv   = w_fill & line_end;

    frame_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .Clk_in      (Clk_in),
        .Rst_n_in    (Rst_n_in),
        .i_clr       (w_start),
        .i_inc       (w_wr),
        .i_line_adv  (w_adv),
        .o_col       (w_col),
        .o_addr      (w_addr),
        .o_line_full (w_line_full),
        .o_last_line (w_last_line)
    );

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_state     <= ST_IDLE;
            r_ready_q   <= 1'b0;
            r_seen_busy <= 1'b0;
        end else begin
            r_ready_q   <= pixel_ready;
            r_seen_busy <= (r_state == ST_WAIT_ROT) & (r_seen_busy | rot_busy);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start)
                        r_state <= ST_FILL;
                end
                ST_FILL: begin
                    if (!pixel_ready)
                        r_state <= ST_IDLE;
                    else if (w_adv && w_last_line)
                        r_state <= ST_HANDOFF;
                end
                ST_HANDOFF:  r_state <= ST_WAIT_ROT;
                ST_WAIT_ROT: begin
                    if (r_seen_busy && !rot_busy)
                        r_state <= ST_IDLE;
                end
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rot_start <= 1'b0;
        end else begin
            r_wr_en     <= w_wr;
            r_rot_start <= w_adv & w_last_line;
            if (w_wr) begin
                r_wr_addr <= w_addr;
                r_wr_data <= pixel_data;
            end
        end
    end

`ifdef LINE_CHECK_EN
    logic r_line_err;
    logic w_col_done;
    logic w_err_set;

    // Column count as it will stand after this cycle's write, if any.
    assign w_col_done = w_line_full |
                        (pixel_valid & (w_col == COL_W'(IMG_W - 1)));
    assign w_err_set  = w_fill & ((pixel_valid & w_line_full) |
                                  (line_end & ~w_col_done));

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in)
            r_line_err <= 1'b0;
        else if (w_start)
            r_line_err <= 1'b0;
        else if (w_err_set)
            r_line_err <= 1'b1;
    end

    assign line_err = r_line_err;
`else
    logic w_unused_col;
    assign w_unused_col = ^w_col;
    assign line_err     = 1'b0;
`endif

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign rot_start  = r_rot_start;
    assign frame_done = r_rot_start;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed/randomized bench for frame_write_ctrl at IMG_W=4, IMG_H=3.
module tb_frame_write_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          Clk_in = 1'b0;
    logic          Rst_n_in;
    logic          pixel_ready;
    logic          pixel_valid;
    logic          line_end;
    logic [23:0]   pixel_data;
    logic          rot_busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          rot_start;
    logic          frame_done;
    logic          busy;
    logic          line_err;

    frame_write_ctrl #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .Clk_in      (Clk_in),
        .Rst_n_in    (Rst_n_in),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .line_end    (line_end),
        .pixel_data  (pixel_data),
        .rot_busy    (rot_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rot_start   (rot_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .line_err    (line_err)
    );

    always #5 Clk_in = ~Clk_in;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int rot_cnt = 0;
    int rot_cyc = -1;
    int fd_bad  = 0;

    logic [27:0] obs_q[$];
    logic [27:0] exp_q[$];

    // Output monitor: records every write and rot_start pulse.
    always @(posedge Clk_in) begin
        cyc++;
        #1;
        if (wr_en === 1'b1)
            obs_q.push_back({wr_addr, wr_data});
        if (rot_start === 1'b1) begin
            rot_cnt++;
            rot_cyc = cyc;
        end
        if (rot_start !== frame_done)
            fd_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_writes(input string tag);
        int n;
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // One line: n pixels at random data; model writes row*W+k for k<W.
    task automatic send_line(input int r, input int n, input bit coin,
                             inout bit err, output int le);
        logic [23:0] d;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk_in);
            d           = 24'($urandom);
            pixel_valid = 1'b1;
            pixel_data  = d;
            line_end    = coin && (k == n - 1);
            if (k < W)
                exp_q.push_back({4'(r * W + k), d});
        end
        if (!coin) begin
            @(negedge Clk_in);
            pixel_valid = 1'b0;
            line_end    = 1'b1;
        end
        le = cyc + 1;
        @(negedge Clk_in);
        pixel_valid = 1'b0;
        line_end    = 1'b0;
        if (n != W)
            err = 1'b1;
    endtask

    task automatic start_frame();
        @(negedge Clk_in);
        pixel_ready = 1'b0;
        pixel_valid = 1'b0;
        line_end    = 1'b0;
        @(negedge Clk_in);
        pixel_ready = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = 24'hBADBAD;
    endtask

    task automatic frame(input int n0, input int n1, input int n2,
                         input bit coin0, output bit err, output int le);
        int n[3];
        n   = '{n0, n1, n2};
        err = 1'b0;
        start_frame();
        for (int r = 0; r < H; r++)
            send_line(r, n[r], (r == 0) && coin0, err, le);
    endtask

    task automatic post(input string tag, input bit err, input int le,
                        input int rot0, input bit retrig);
        int t;
        logic exp_err;
`ifdef LINE_CHECK_EN
        exp_err = err;
`else
        exp_err = 1'b0;
`endif
        repeat (2) @(negedge Clk_in);
        chk({tag, "_rotcnt"}, rot_cnt - rot0, 1);
        chk({tag, "_rottime"}, rot_cyc, le);
        chk({tag, "_busy"}, busy, 1'b1);
        cmp_writes(tag);
        @(negedge Clk_in);
        rot_busy    = 1'b1;
        pixel_ready = 1'b0;
        @(negedge Clk_in);
        if (retrig) begin
            pixel_ready = 1'b1;
            pixel_valid = 1'b1;
            pixel_data  = 24'($urandom);
        end
        repeat (2) @(negedge Clk_in);
        chk({tag, "_busy_rot"}, busy, 1'b1);
        rot_busy = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 10) begin
            @(negedge Clk_in);
            t++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
        if (retrig) begin
            repeat (3) @(negedge Clk_in);
            chk({tag, "_retrig_busy"}, busy, 1'b0);
            chk({tag, "_retrig_nwr"}, obs_q.size(), 0);
            pixel_valid = 1'b0;
        end
        chk({tag, "_line_err"}, line_err, exp_err);
    endtask

    initial begin
        bit err;
        int le;
        int rot0;

        Rst_n_in    = 1'b0;
        pixel_ready = 1'b0;
        pixel_valid = 1'b0;
        line_end    = 1'b0;
        pixel_data  = '0;
        rot_busy    = 1'b0;
        #12;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, '0);
        chk("rst_rot_start", rot_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_line_err", line_err, 1'b0);
        @(negedge Clk_in);
        Rst_n_in = 1'b1;

        // Rise while the rotation engine is busy: ignored.
        rot_busy = 1'b1;
        @(negedge Clk_in);
        pixel_ready = 1'b1;
        repeat (3) begin
            @(negedge Clk_in);
            pixel_valid = 1'b1;
            pixel_data  = 24'($urandom);
        end
        @(negedge Clk_in);
        chk("ign_busy", busy, 1'b0);
        chk("ign_nwr", obs_q.size(), 0);
        pixel_valid = 1'b0;
        pixel_ready = 1'b0;
        rot_busy    = 1'b0;

        rot0 = rot_cnt;
        frame(4, 4, 4, 1'b0, err, le);
        post("nominal", err, le, rot0, 1'b0);

        rot0 = rot_cnt;
        frame(4, 2, 4, 1'b0, err, le);
        post("short", err, le, rot0, 1'b0);

        rot0 = rot_cnt;
        frame(5, 4, 4, 1'b1, err, le);
        post("long", err, le, rot0, 1'b0);

        rot0 = rot_cnt;
        frame(4, 4, 4, 1'b1, err, le);
        post("coin_full", err, le, rot0, 1'b1);

        // Abort after 6 pixels.
        rot0 = rot_cnt;
        err  = 1'b0;
        start_frame();
        send_line(0, 4, 1'b0, err, le);
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk_in);
            pixel_valid = 1'b1;
            pixel_data  = 24'($urandom);
            exp_q.push_back({4'(W + k), pixel_data});
        end
        @(negedge Clk_in);
        pixel_ready = 1'b0;
        pixel_valid = 1'b0;
        repeat (2) @(negedge Clk_in);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rot", rot_cnt - rot0, 0);
        cmp_writes("abort");

        rot0 = rot_cnt;
        frame(4, 4, 4, 1'b0, err, le);
        post("post_abort", err, le, rot0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        rot0 = rot_cnt;
        start_frame();
        repeat (3) begin
            @(negedge Clk_in);
            pixel_valid = 1'b1;
            pixel_data  = 24'($urandom);
        end
        @(posedge Clk_in);
        #2;
        chk("prerst_wr_en", wr_en, 1'b1);
        Rst_n_in = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 1'b0);
        chk("arst_wr_addr", wr_addr, '0);
        chk("arst_wr_data", wr_data, '0);
        chk("arst_busy", busy, 1'b0);
        @(negedge Clk_in);
        pixel_ready = 1'b0;
        pixel_valid = 1'b0;
        Rst_n_in    = 1'b1;
        @(negedge Clk_in);
        chk("arst_rot", rot_cnt - rot0, 0);
        obs_q.delete();
        exp_q.delete();

        rot0 = rot_cnt;
        frame(4, 4, 4, 1'b0, err, le);
        post("post_rst", err, le, rot0, 1'b0);

        chk("frame_done_eq", fd_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
